// File: rtl/systolic_sched_pkg.sv
// Shared types and helpers for the systolic cluster scheduler.
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StClear,
    StLoad,
    StCompute,
    StDrain,
    StDone
  } sched_state_e;

  localparam logic PhaseWeight = 1'b0;
  localparam logic PhaseAct    = 1'b1;

  // Cycles needed to flush the diagonal operand skew through an N x N array.
  function automatic int unsigned skew_len(input int unsigned n);
    return 2 * (n - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NumReq-1:0] i_req,
  input  logic              i_advance,
  output logic [NumReq-1:0] o_grant,
  output logic [IdxW-1:0]   o_grant_idx,
  output logic              o_any
);

  logic [IdxW-1:0] r_ptr;

  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      if (!o_any && i_req[(int'(r_ptr) + off) % int'(NumReq)]) begin
        o_any       = 1'b1;
        o_grant_idx = IdxW'((int'(r_ptr) + off) % int'(NumReq));
      end
    end
    o_grant = o_any ? (NumReq'(1) << o_grant_idx) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (int'(o_grant_idx) == int'(NumReq) - 1) ? '0 : o_grant_idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/systolic_cluster_scheduler.sv
// Job sequencer for the systolic array cluster: arbitrates tile jobs, allocates a free
// array, walks it through clear/load/compute/drain and tracks unread result slots.
module systolic_cluster_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_ARRAYS = 8,
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned KLEN_BITS  = 8,
  parameter int unsigned MAC_LAT    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*KLEN_BITS-1:0]  i_req_k_len,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [$clog2(NUM_ARRAYS)-1:0] o_arr_select,
  output logic                          o_arr_enable,
  output logic                          o_arr_clear_acc,
  output logic                          o_arr_load_weights,
  output logic                          o_arr_compute_enable,
  output logic                          o_arr_broadcast,
  output logic                          o_feed_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_feed_owner,
  output logic                          o_feed_phase,
  output logic [KLEN_BITS-1:0]          o_feed_index,
  output logic                          o_done_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_done_owner,
  output logic [$clog2(NUM_ARRAYS)-1:0] o_done_array,
  input  logic [$clog2(NUM_ARRAYS)-1:0] i_rd_select,
  output logic                          o_rd_free,
  input  logic                          i_rel_valid,
  input  logic [$clog2(NUM_ARRAYS)-1:0] i_rel_array,
  output logic [NUM_ARRAYS-1:0]         o_slot_pending
);

  localparam int unsigned ReqW    = $clog2(NUM_REQ);
  localparam int unsigned ArrW    = $clog2(NUM_ARRAYS);
  localparam int unsigned CntW    = KLEN_BITS + 1;
  localparam int unsigned SkewLen = skew_len(ARRAY_SIZE);

  sched_state_e r_state, w_next_state;

  logic                  r_armed;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       r_k_len;
  logic [ReqW-1:0]       r_owner;
  logic [ArrW-1:0]       r_arr;
  logic [NUM_ARRAYS-1:0] r_pending;

  logic [NUM_REQ-1:0]    w_arb_grant;
  logic [ReqW-1:0]       w_arb_idx;
  logic                  w_arb_any;
  logic                  w_any_free;
  logic [ArrW-1:0]       w_free_idx;
  logic                  w_grant_ok;
  logic                  w_grant_fire;
  logic                  w_load_last;
  logic                  w_compute_last;
  logic                  w_drain_last;
  logic [NUM_ARRAYS-1:0] w_done_mask;
  logic [NUM_ARRAYS-1:0] w_rel_mask;

  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_rr_arbiter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req_valid),
    .i_advance   (w_grant_fire),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx),
    .o_any       (w_arb_any)
  );

  // Lowest-index free array wins allocation.
  always_comb begin
    w_any_free = ~&r_pending;
    w_free_idx = '0;
    for (int i = int'(NUM_ARRAYS) - 1; i >= 0; i--) begin
      if (!r_pending[i]) w_free_idx = ArrW'(i);
    end
  end

  assign w_grant_ok     = (r_state == StIdle) && w_arb_any && w_any_free;
  assign w_grant_fire   = i_enable && w_grant_ok;
  assign w_load_last    = (r_cnt == CntW'(ARRAY_SIZE - 1));
  assign w_compute_last = (r_cnt == r_k_len + CntW'(SkewLen - 1));
  assign w_drain_last   = (r_cnt == CntW'(MAC_LAT - 1));
  assign w_done_mask    = (r_state == StDone) ? (NUM_ARRAYS'(1) << r_arr) : '0;
  assign w_rel_mask     = i_rel_valid ? (NUM_ARRAYS'(1) << i_rel_array) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StInit;
    end else if (i_enable) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StInit:    if (r_armed) w_next_state = StIdle;
      StIdle:    if (w_grant_ok) w_next_state = StClear;
      StClear:   w_next_state = (r_k_len == '0) ? StDone : StLoad;
      StLoad:    if (w_load_last) w_next_state = StCompute;
      StCompute: if (w_compute_last) w_next_state = StDrain;
      StDrain:   if (w_drain_last) w_next_state = StDone;
      StDone:    w_next_state = StIdle;
      default:   w_next_state = StInit;
    endcase
  end

  // r_armed keeps the INIT strobes off while reset is still asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_k_len   <= '0;
      r_owner   <= '0;
      r_arr     <= '0;
      r_pending <= '0;
    end else if (i_enable) begin
      if (r_state == StInit) r_armed <= 1'b1;
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state inside {StLoad, StCompute, StDrain}) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_grant_ok) begin
        r_k_len <= {1'b0, i_req_k_len[int'(w_arb_idx)*KLEN_BITS +: KLEN_BITS]};
        r_owner <= w_arb_idx;
        r_arr   <= w_free_idx;
      end
      r_pending <= (r_pending & ~w_rel_mask) | w_done_mask;
    end
  end

  always_comb begin
    o_req_ready          = '0;
    o_arr_enable         = 1'b0;
    o_arr_clear_acc      = 1'b0;
    o_arr_load_weights   = 1'b0;
    o_arr_compute_enable = 1'b0;
    o_arr_broadcast      = 1'b0;
    o_feed_valid         = 1'b0;
    o_feed_phase         = PhaseWeight;
    o_feed_index         = '0;
    o_done_valid         = 1'b0;
    o_rd_free            = (r_state == StIdle);
    o_arr_select         = (r_state == StIdle) ? i_rd_select : r_arr;
    o_feed_owner         = r_owner;
    o_done_owner         = r_owner;
    o_done_array         = r_arr;
    o_slot_pending       = r_pending | (i_enable ? w_done_mask : '0);
    if (i_enable) begin
      unique case (r_state)
        StInit: begin
          o_arr_enable    = r_armed;
          o_arr_clear_acc = r_armed;
          o_arr_broadcast = r_armed;
        end
        StIdle: o_req_ready = w_grant_ok ? w_arb_grant : '0;
        StClear: begin
          o_arr_enable    = 1'b1;
          o_arr_clear_acc = 1'b1;
        end
        StLoad: begin
          o_arr_enable       = 1'b1;
          o_arr_load_weights = 1'b1;
          o_feed_valid       = 1'b1;
          o_feed_index       = r_cnt[KLEN_BITS-1:0];
        end
        StCompute: begin
          o_arr_enable         = 1'b1;
          o_arr_compute_enable = 1'b1;
          o_feed_phase         = PhaseAct;
          o_feed_valid         = (r_cnt < r_k_len);
          o_feed_index         = o_feed_valid ? r_cnt[KLEN_BITS-1:0] : '0;
        end
        StDrain: o_arr_enable = 1'b1;
        StDone: begin
          o_arr_enable = 1'b1;
          o_done_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_cluster_scheduler.sv
// Scoreboard bench for systolic_cluster_scheduler: stimulus queues expected grants,
// a negedge monitor checks grants, per-job strobe sequences and completions.
module tb_systolic_cluster_scheduler;

  localparam int NR = 4;
  localparam int NA = 8;
  localparam int KB = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable;
  logic [NR-1:0]    req_valid;
  logic [NR*KB-1:0] req_k_len;
  logic [NR-1:0]    req_ready;
  logic [2:0]       arr_select;
  logic             arr_enable, arr_clear_acc, arr_load_weights, arr_compute_enable;
  logic             arr_broadcast, feed_valid, feed_phase, done_valid, rd_free, rel_valid;
  logic [1:0]       feed_owner, done_owner;
  logic [KB-1:0]    feed_index;
  logic [2:0]       done_array, rd_select, rel_array;
  logic [NA-1:0]    slot_pending;

  systolic_cluster_scheduler dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_enable             (enable),
    .i_req_valid          (req_valid),
    .i_req_k_len          (req_k_len),
    .o_req_ready          (req_ready),
    .o_arr_select         (arr_select),
    .o_arr_enable         (arr_enable),
    .o_arr_clear_acc      (arr_clear_acc),
    .o_arr_load_weights   (arr_load_weights),
    .o_arr_compute_enable (arr_compute_enable),
    .o_arr_broadcast      (arr_broadcast),
    .o_feed_valid         (feed_valid),
    .o_feed_owner         (feed_owner),
    .o_feed_phase         (feed_phase),
    .o_feed_index         (feed_index),
    .o_done_valid         (done_valid),
    .o_done_owner         (done_owner),
    .o_done_array         (done_array),
    .i_rd_select          (rd_select),
    .o_rd_free            (rd_free),
    .i_rel_valid          (rel_valid),
    .i_rel_array          (rel_array),
    .o_slot_pending       (slot_pending)
  );

  always #5 clk = ~clk;

  typedef struct {int req; int arr; int k; int stall;} job_t;
  typedef struct {int owner; int arr; int k; int due;} done_t;

  job_t  gq[$];
  done_t dq[$];
  job_t  j;
  done_t d;

  int checks = 0, fails = 0, cyc = 0;
  int n_grants = 0, n_dones = 0;
  int c_load, c_comp, c_act, c_clear, idx_err, cur_owner, cur_arr;
  bit in_job = 0;
  logic [NA-1:0] model_pending = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes within a job and scores grants and completions.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_job = 0;
    end else begin
      if (in_job) begin
        if (arr_enable && arr_select != 3'(cur_arr)) idx_err++;
        if (arr_clear_acc) c_clear++;
        if (arr_load_weights) begin
          if (!feed_valid || feed_phase !== 1'b0 || int'(feed_index) != c_load) idx_err++;
          c_load++;
        end
        if (arr_compute_enable) begin
          c_comp++;
          if (feed_valid) begin
            if (feed_phase !== 1'b1 || int'(feed_index) != c_act) idx_err++;
            c_act++;
          end
        end
        if (feed_valid && int'(feed_owner) != cur_owner) idx_err++;
      end
      if (|req_ready) begin
        n_grants++;
        if (gq.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'd0);
        end else begin
          j = gq.pop_front();
          check("grant_onehot", 64'(req_ready), 64'd1 << j.req);
          c_load = 0; c_comp = 0; c_act = 0; c_clear = 0; idx_err = 0;
          cur_owner = j.req; cur_arr = j.arr; in_job = 1;
          dq.push_back('{j.req, j.arr, j.k, cyc + ((j.k == 0) ? 2 : j.k + 26) + j.stall});
        end
      end
      if (done_valid) begin
        n_dones++;
        in_job = 0;
        if (dq.size() == 0) begin
          check("unexpected_done", 64'(done_valid), 64'd0);
        end else begin
          d = dq.pop_front();
          model_pending[d.arr] = 1'b1;
          check("done_owner", 64'(done_owner), 64'(d.owner));
          check("done_array", 64'(done_array), 64'(d.arr));
          check("done_cycle", 64'(cyc), 64'(d.due));
          check("clear_cycles", 64'(c_clear), 64'd1);
          check("load_cycles", 64'(c_load), (d.k == 0) ? 64'd0 : 64'd8);
          check("compute_cycles", 64'(c_comp), (d.k == 0) ? 64'd0 : 64'(d.k + 14));
          check("act_feed_cycles", 64'(c_act), 64'(d.k));
          check("feed_select_seq", 64'(idx_err), 64'd0);
          check("done_slot_pending", 64'(slot_pending), 64'(model_pending));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int nb;
    rst_n = 1'b0;
    gq.delete();
    dq.delete();
    model_pending = '0;
    tick(2);
    check("reset_pending", 64'(slot_pending), 64'd0);
    check("reset_outputs", 64'({req_ready, arr_enable, arr_clear_acc, arr_load_weights,
                                arr_compute_enable, arr_broadcast, feed_valid, done_valid,
                                rd_free, arr_select}), 64'd0);
    rst_n = 1'b1;
    nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (arr_broadcast && arr_clear_acc && arr_enable) nb++;
    end
    check("init_pulse_cycles", 64'(nb), 64'd1);
    check("rd_free_after_init", 64'(rd_free), 64'd1);
    tick();
  endtask

  task automatic submit(input int r, input int k, input int arr, input int stall);
    gq.push_back('{r, arr, k, stall});
    req_k_len[r*KB +: KB] = KB'(k);
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    for (int i = 0; i < budget && n_grants < target; i++) tick();
    check("grant_count", 64'(n_grants), 64'(target));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !(dq.size() == 0 && gq.size() == 0 && rd_free); i++) tick();
    check("jobs_drained", 64'(dq.size() + gq.size()), 64'd0);
  endtask

  initial begin
    int base;
    enable = 1'b1; req_valid = '0; req_k_len = '0;
    rd_select = '0; rel_valid = 1'b0; rel_array = '0;
    do_reset();

    // Result-read path follows rd_select while idle.
    rd_select = 3'd3;
    tick();
    check("idle_rd_select", 64'(arr_select), 64'd3);

    // Single job, full-length timing.
    submit(2, 8, 0, 0);
    wait_grants(n_grants + 1, 10);
    req_valid = '0;
    wait_idle(100);
    check("pending_after_job", 64'(slot_pending), 64'h01);

    // Round-robin over continuously valid requesters.
    do_reset();
    req_k_len = {8'd3, 8'd2, 8'd1, 8'd4};
    gq.push_back('{0, 0, 4, 0});
    gq.push_back('{1, 1, 1, 0});
    gq.push_back('{2, 2, 2, 0});
    gq.push_back('{3, 3, 3, 0});
    gq.push_back('{0, 4, 4, 0});
    base = n_grants;
    req_valid = 4'hF;
    wait_grants(base + 5, 400);
    req_valid = '0;
    wait_idle(100);

    // Fill remaining slots, then stall until a release frees array 5.
    gq.push_back('{1, 5, 1, 0});
    gq.push_back('{2, 6, 2, 0});
    gq.push_back('{3, 7, 3, 0});
    req_valid = 4'hF;
    wait_grants(base + 8, 300);
    wait_idle(100);
    tick(20);
    check("no_grant_when_full", 64'(n_grants), 64'(base + 8));
    check("all_pending", 64'(slot_pending), 64'(model_pending));
    gq.push_back('{0, 5, 4, 0});
    rel_array = 3'd5; rel_valid = 1'b1;
    model_pending[5] = 1'b0;
    tick();
    rel_valid = 1'b0;
    check("release_clears", 64'(slot_pending), 64'(model_pending));
    wait_grants(base + 9, 2);
    req_valid = '0;
    wait_idle(100);

    // Release a pending slot, then release it again (ignored).
    rel_array = 3'd2; rel_valid = 1'b1; model_pending[2] = 1'b0;
    tick();
    rel_array = 3'd2;
    tick();
    rel_valid = 1'b0;
    tick();
    check("double_release", 64'(slot_pending), 64'(model_pending));

    // Zero-length job skips load and compute.
    do_reset();
    submit(1, 0, 0, 0);
    wait_grants(n_grants + 1, 10);
    req_valid = '0;
    wait_idle(20);

    // Three-cycle freeze mid-compute shifts completion by three cycles.
    do_reset();
    submit(0, 8, 0, 3);
    wait_grants(n_grants + 1, 10);
    req_valid = '0;
    tick(12);
    enable = 1'b0;
    @(negedge clk);
    check("freeze_arr_enable", 64'(arr_enable), 64'd0);
    check("freeze_compute", 64'(arr_compute_enable), 64'd0);
    tick(3);
    enable = 1'b1;
    wait_idle(100);

    // Async reset mid-load abandons the job and reruns INIT.
    submit(3, 8, 1, 0);
    wait_grants(n_grants + 1, 10);
    req_valid = '0;
    tick(3);
    #2;
    base = n_dones;
    do_reset();
    tick(60);
    check("no_done_after_reset", 64'(n_dones), 64'(base));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
